// File: rtl/srl_bit_fifo_ctrl.sv
// Bit-serial elastic FIFO: a DEPTH-bit shift-register store addressed by occupancy,
// so the oldest accepted bit is always presented at the tap.
module srl_bit_fifo_ctrl #(
   parameter int DEPTH        = 128,
   parameter int AFULL_THRESH = DEPTH - 8
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       flush,
   input  logic                       s_valid,
   input  logic                       s_data,
   output logic                       s_ready,
   output logic                       m_valid,
   output logic                       m_data,
   input  logic                       m_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [DEPTH-1:0] mem;
   logic [LW-1:0]    level_q;
   logic [LW-1:0]    level_m1;
   logic [AW-1:0]    tap;
   logic             push;
   logic             pop;

   // Status flags decode straight from the registered level.
   assign full        = (level_q == LW'(DEPTH));
   assign empty       = (level_q == '0);
   assign almost_full = (level_q >= LW'(AFULL_THRESH));
   assign s_ready     = !full;
   assign m_valid     = !empty;
   assign level       = level_q;

   assign push = s_valid & s_ready;
   assign pop  = m_valid & m_ready;

   // level-1 always fits in AW bits while non-empty; the empty case is masked below.
   assign level_m1 = level_q - LW'(1);
   assign tap      = empty ? '0 : level_m1[AW-1:0];
   assign m_data   = empty ? 1'b0 : mem[tap];

   // Store is deliberately unreset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem <= {mem[DEPTH-2:0], s_data};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         level_q <= '0;
      else if (flush)
         level_q <= '0;
      else if (push && !pop)
         level_q <= level_q + LW'(1);
      else if (pop && !push)
         level_q <= level_q - LW'(1);
   end

endmodule

// File: tb/tb_srl_bit_fifo_ctrl.sv
// Scoreboard bench for srl_bit_fifo_ctrl: a queue model tracks accepted bits and
// every output is compared on the falling edge.
module tb_srl_bit_fifo_ctrl;
   localparam int DEPTH = 128;
   localparam int AFT   = 120;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 0;
   logic          rstn = 0;
   logic          flush = 0, s_valid = 0, s_data = 0, m_ready = 0;
   logic          s_ready, m_valid, m_data, full, empty, almost_full;
   logic [LW-1:0] level;

   int n_chk = 0;
   int n_fail = 0;
   bit q[$];

   srl_bit_fifo_ctrl #(.DEPTH(DEPTH), .AFULL_THRESH(AFT)) dut (
      .clk(clk), .rstn(rstn), .flush(flush),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
      .level(level), .full(full), .empty(empty), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_outputs();
      int  sz;
      bit  head;
      sz   = q.size();
      head = (sz > 0) ? q[0] : 1'b0;
      chk("level",       32'(level),       32'(sz));
      chk("lvl_range",   32'(level <= DEPTH), 32'd1);
      chk("empty",       32'(empty),       32'(sz == 0));
      chk("full",        32'(full),        32'(sz == DEPTH));
      chk("almost_full", 32'(almost_full), 32'(sz >= AFT));
      chk("s_ready",     32'(s_ready),     32'(sz != DEPTH));
      chk("m_valid",     32'(m_valid),     32'(sz != 0));
      chk("m_data",      32'(m_data),      32'(head));
   endtask

   task automatic chk_reset_vals();
      chk("rst_level",   32'(level),       32'd0);
      chk("rst_empty",   32'(empty),       32'd1);
      chk("rst_full",    32'(full),        32'd0);
      chk("rst_afull",   32'(almost_full), 32'd0);
      chk("rst_m_valid", 32'(m_valid),     32'd0);
      chk("rst_m_data",  32'(m_data),      32'd0);
      chk("rst_s_ready", 32'(s_ready),     32'd1);
   endtask

   // One clock: check current outputs, drive the next inputs, advance the model.
   task automatic cycle(input bit sv, input bit sd, input bit mr, input bit fl);
      bit mpush, mpop;
      @(negedge clk);
      chk_outputs();
      s_valid = sv; s_data = sd; m_ready = mr; flush = fl;
      mpush = sv && (q.size() < DEPTH);
      mpop  = mr && (q.size() > 0);
      if (fl) q.delete();
      else begin
         if (mpop)  void'(q.pop_front());
         if (mpush) q.push_back(sd);
      end
   endtask

   task automatic mid_reset();
      @(negedge clk);
      s_valid = 0; m_ready = 0; flush = 0;
      #2 rstn = 0;
      #1 chk_reset_vals();
      q.delete();
      @(negedge clk);
      chk_reset_vals();
      rstn = 1;
   endtask

   initial begin
      bit v;
      // Reset held with s_valid asserted: nothing may be accepted.
      s_valid = 1; s_data = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk_reset_vals();
      end
      rstn = 1;
      q.push_back(1'b1);           // accepted on the first edge after release
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Ordered transfer 1,0,1,1.
      cycle(1, 1, 0, 0); cycle(1, 0, 0, 0); cycle(1, 1, 0, 0); cycle(1, 1, 0, 0);
      for (int i = 0; i < 4; i++) cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);

      // Fill past full with a random stream, then drain.
      for (int i = 0; i < 132; i++) cycle(1, 1'($urandom), 0, 0);
      for (int i = 0; i < 131; i++) cycle(0, 0, 1, 0);
      cycle(0, 0, 0, 0);

      // Simultaneous push/pop at level 5, and at full.
      for (int i = 0; i < 5; i++) cycle(1, 1'($urandom), 0, 0);
      for (int i = 0; i < 50; i++) cycle(1, 1'($urandom), 1, 0);
      for (int i = 0; i < 125; i++) cycle(1, 1'($urandom), 0, 0);
      for (int i = 0; i < 4; i++) cycle(1, 1'($urandom), 1, 0);
      for (int i = 0; i < 130; i++) cycle(0, 0, 1, 0);

      // Flush priority at level 10.
      for (int i = 0; i < 10; i++) cycle(1, 1'($urandom), 0, 0);
      cycle(1, 1, 1, 1);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 1, 0);

      // Reset in mid-operation.
      for (int i = 0; i < 7; i++) cycle(1, 1, 0, 0);
      mid_reset();
      cycle(1, 0, 0, 0);
      cycle(0, 0, 1, 0);

      // Random stress, biased in phases so both boundaries are reached.
      for (int i = 0; i < 10000; i++) begin
         int ph;
         ph = (i / 1000) % 3;
         v  = (ph == 1) ? ($urandom_range(0, 9) < 8) : (ph == 2) ? ($urandom_range(0, 9) < 2)
                                                                 : 1'($urandom);
         cycle(v, 1'($urandom),
               (ph == 1) ? ($urandom_range(0, 9) < 2) : (ph == 2) ? ($urandom_range(0, 9) < 8)
                                                                  : 1'($urandom),
               $urandom_range(0, 99) == 0);
      end
      cycle(0, 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
